// File: rtl/dru_pkg.sv
// Shared constants and helpers for the DRU receive path.
package dru_pkg;

  localparam int unsigned DRU_MAX_BITS = 3;
  localparam int unsigned DRU_NUM_W    = 2;

  // Encoding of the per-cycle recovered-bit count
  localparam logic [DRU_NUM_W-1:0] NUM_BITS_0 = 2'd0;
  localparam logic [DRU_NUM_W-1:0] NUM_BITS_1 = 2'd1;
  localparam logic [DRU_NUM_W-1:0] NUM_BITS_2 = 2'd2;
  localparam logic [DRU_NUM_W-1:0] NUM_BITS_3 = 2'd3;

  // Width of a counter that can hold 0..acc_w
  function automatic int unsigned fill_w(input int unsigned acc_w);
    return $clog2(acc_w + 1);
  endfunction

endpackage

// File: rtl/dru_bit_gearbox_if.sv
// Word-output stream of the receive gearbox.
interface dru_bit_gearbox_if #(
  parameter int unsigned WORD_W = 10
);

  logic [WORD_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/dru_bit_accumulator.sv
// Bit accumulator: append of 0..3 bits, bitslip and fill tracking.
// Oldest bit sits at acc[fill-1], newest at acc[0].
module dru_bit_accumulator
  import dru_pkg::*;
#(
  parameter  int unsigned WORD_W = 10,
  parameter  int unsigned ACC_W  = 2 * WORD_W,
  localparam int unsigned FILL_W = fill_w(ACC_W)
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic [DRU_MAX_BITS-1:0] in_bits,
  input  logic [DRU_NUM_W-1:0]    num,
  input  logic                    bitslip,
  input  logic                    take,
  output logic [ACC_W-1:0]        acc_c,
  output logic [FILL_W-1:0]       fill_c,
  output logic                    drop_c,
  output logic [FILL_W-1:0]       fill
);

  logic [ACC_W-1:0]        acc;
  logic [FILL_W:0]         sum_c;
  logic [FILL_W-1:0]       fill_app_c;
  logic [DRU_MAX_BITS-1:0] field_c;

  // Append (or drop on overflow), then apply bitslip to the fill count
  always_comb begin
    sum_c      = {1'b0, fill} + (FILL_W + 1)'(num);
    drop_c     = sum_c > (FILL_W + 1)'(ACC_W);
    field_c    = in_bits & ~(DRU_MAX_BITS'(3'b111) << num);
    acc_c      = acc;
    fill_app_c = fill;
    if (!drop_c) begin
      acc_c      = (acc << num) | ACC_W'(field_c);
      fill_app_c = FILL_W'(sum_c);
    end
    fill_c = fill_app_c;
    if (bitslip && (fill_app_c != '0)) begin
      fill_c = fill_app_c - FILL_W'(1);
    end
  end

  // Storage update; extraction only lowers the fill, stale upper bits are ignored
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      acc  <= '0;
      fill <= '0;
    end else begin
      acc  <= acc_c;
      fill <= take ? (fill_c - FILL_W'(WORD_W)) : fill_c;
    end
  end

endmodule

// File: rtl/dru_bit_gearbox.sv
// Receive gearbox: packs 0..3 recovered bits/cycle MSB-first into WORD_W-bit
// words on a valid/ready stream, with bitslip and sticky overflow.
module dru_bit_gearbox
  import dru_pkg::*;
#(
  parameter  int unsigned WORD_W = 10,
  parameter  int unsigned ACC_W  = 2 * WORD_W,
  localparam int unsigned FILL_W = fill_w(ACC_W)
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic [DRU_MAX_BITS-1:0] in_bits,
  input  logic [DRU_NUM_W-1:0]    in_num,
  input  logic                    in_en,
  input  logic                    bitslip,
  dru_bit_gearbox_if.master       m,
  output logic                    overflow,
  output logic [FILL_W-1:0]       fill_level
);

  logic [DRU_NUM_W-1:0] num_c;
  logic [ACC_W-1:0]     acc_c;
  logic [FILL_W-1:0]    fill_c;
  logic                 drop_c;
  logic                 slot_free_c;
  logic                 take_c;
  logic [WORD_W-1:0]    word_c;
  logic [WORD_W-1:0]    data_q;
  logic                 valid_q;

  // Disabled input behaves as a zero-bit cycle
  assign num_c = in_en ? in_num : NUM_BITS_0;

  dru_bit_accumulator #(
    .WORD_W (WORD_W),
    .ACC_W  (ACC_W)
  ) u_acc (
    .clk     (clk),
    .aresetn (aresetn),
    .in_bits (in_bits),
    .num     (num_c),
    .bitslip (bitslip),
    .take    (take_c),
    .acc_c   (acc_c),
    .fill_c  (fill_c),
    .drop_c  (drop_c),
    .fill    (fill_level)
  );

  // Extract the oldest WORD_W bits when the output slot can accept a word
  always_comb begin
    slot_free_c = !valid_q || m.m_ready;
    take_c      = slot_free_c && (fill_c >= FILL_W'(WORD_W));
    word_c      = WORD_W'(acc_c >> (fill_c - FILL_W'(WORD_W)));
  end

  // Output register and sticky overflow
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      overflow <= 1'b0;
    end else begin
      if (drop_c) begin
        overflow <= 1'b1;
      end
      if (slot_free_c) begin
        valid_q <= take_c;
        if (take_c) begin
          data_q <= word_c;
        end
      end
    end
  end

  assign m.m_data  = data_q;
  assign m.m_valid = valid_q;

endmodule

// File: tb/tb_dru_bit_gearbox.sv
// Scoreboard bench for dru_bit_gearbox (WORD_W=8, ACC_W=16).
module tb_dru_bit_gearbox;
  import dru_pkg::*;

  localparam int unsigned WORD_W = 8;
  localparam int unsigned ACC_W  = 16;
  localparam int unsigned FILL_W = fill_w(ACC_W);

  logic              clk = 1'b0;
  logic              aresetn = 1'b0;
  logic [2:0]        in_bits = '0;
  logic [1:0]        in_num = '0;
  logic              in_en = 1'b1;
  logic              bitslip = 1'b0;
  logic              overflow;
  logic [FILL_W-1:0] fill_level;

  int n_vec = 0;
  int n_bad = 0;
  logic [WORD_W-1:0] exp_q[$];

  dru_bit_gearbox_if #(.WORD_W(WORD_W)) bus ();

  dru_bit_gearbox #(.WORD_W(WORD_W), .ACC_W(ACC_W)) dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .in_bits    (in_bits),
    .in_num     (in_num),
    .in_en      (in_en),
    .bitslip    (bitslip),
    .m          (bus),
    .overflow   (overflow),
    .fill_level (fill_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [2:0] b, input logic [1:0] n,
                      input logic en = 1'b1, input logic slip = 1'b0);
    in_bits = b;
    in_num  = n;
    in_en   = en;
    bitslip = slip;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(3'b000, 2'd0);
  endtask

  // Monitor: pop on every transfer, and check the word holds while stalled
  logic              stalled = 1'b0;
  logic [WORD_W-1:0] held;
  always @(negedge clk) begin
    if (stalled && aresetn) begin
      chk("stall_data", 32'(bus.m_data), 32'(held));
      chk("stall_valid", 32'(bus.m_valid), 32'd1);
    end
    stalled = aresetn && bus.m_valid && !bus.m_ready;
    held    = bus.m_data;
    if (aresetn && bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_word: got 0x%0h expected none", bus.m_data);
      end else begin
        chk("word", 32'(bus.m_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    bus.m_ready = 1'b1;
    idle(2);
    aresetn = 1'b1;
    chk("rst_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_data", 32'(bus.m_data), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_fill", 32'(fill_level), 32'd0);

    // Steady 2 bits/cycle "10" -> AA
    exp_q.push_back(8'hAA);
    for (int i = 0; i < 4; i++) step(3'b010, 2'd2);
    chk("t1_valid", 32'(bus.m_valid), 32'd1);
    chk("t1_fill", 32'(fill_level), 32'd0);
    idle(1);
    chk("t1_valid_drop", 32'(bus.m_valid), 32'd0);

    // Mixed counts -> AB, then BF
    exp_q.push_back(8'hAB);
    step(3'b101, 2'd3);
    step(3'b010, 2'd3);
    step(3'b011, 2'd2);
    exp_q.push_back(8'hBF);
    step(3'b001, 2'd1);
    step(3'b000, 2'd1);
    for (int i = 0; i < 3; i++) step(3'b011, 2'd2);
    idle(1);
    chk("t2_fill", 32'(fill_level), 32'd0);

    // Bitslip discards a preloaded bit, then 5A
    step(3'b001, 2'd1);
    chk("t3_preload", 32'(fill_level), 32'd1);
    step(3'b000, 2'd0, 1'b1, 1'b1);
    chk("t3_slip", 32'(fill_level), 32'd0);
    exp_q.push_back(8'h5A);
    step(3'b001, 2'd2);
    step(3'b001, 2'd2);
    step(3'b010, 2'd2);
    step(3'b010, 2'd2);
    step(3'b000, 2'd0, 1'b1, 1'b1);
    chk("t3_slip_empty", 32'(fill_level), 32'd0);
    idle(1);

    // Backpressure: 9 cycles of 3 ones; last append overflows
    bus.m_ready = 1'b0;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    for (int i = 0; i < 8; i++) step(3'b111, 2'd3);
    chk("t4_fill_full", 32'(fill_level), 32'd16);
    chk("t4_no_ovf_yet", 32'(overflow), 32'd0);
    chk("t4_held_valid", 32'(bus.m_valid), 32'd1);
    step(3'b111, 2'd3);
    chk("t4_ovf", 32'(overflow), 32'd1);
    chk("t4_fill_sat", 32'(fill_level), 32'd16);
    bus.m_ready = 1'b1;
    idle(4);
    chk("t4_drain_fill", 32'(fill_level), 32'd0);
    chk("t4_ovf_sticky", 32'(overflow), 32'd1);
    chk("t4_drained", 32'(bus.m_valid), 32'd0);

    // Disabled / zero-count input does not append
    exp_q.push_back(8'hA9);
    step(3'b101, 2'd3);
    step(3'b111, 2'd3, 1'b0);
    chk("t5_en0", 32'(fill_level), 32'd3);
    step(3'b111, 2'd0);
    chk("t5_num0", 32'(fill_level), 32'd3);
    step(3'b010, 2'd3);
    step(3'b001, 2'd2);
    idle(2);
    chk("t5_fill", 32'(fill_level), 32'd0);

    // Reset mid-operation with a held word and 5 buffered bits
    bus.m_ready = 1'b0;
    step(3'b110, 2'd3);
    step(3'b011, 2'd3);
    step(3'b010, 2'd2);
    step(3'b101, 2'd3);
    step(3'b001, 2'd2);
    chk("t6_pre_fill", 32'(fill_level), 32'd5);
    chk("t6_pre_valid", 32'(bus.m_valid), 32'd1);
    aresetn = 1'b0;
    idle(1);
    aresetn = 1'b1;
    chk("t6_valid", 32'(bus.m_valid), 32'd0);
    chk("t6_fill", 32'(fill_level), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);
    bus.m_ready = 1'b1;
    exp_q.push_back(8'h3C);
    step(3'b001, 2'd3);
    step(3'b111, 2'd3);
    step(3'b000, 2'd2);
    chk("t6_word_valid", 32'(bus.m_valid), 32'd1);
    idle(3);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
